// File: rtl/dsp_pkg.sv
// Shared definitions for the sine-generator front end: sweep FSM encoding
// and default datapath widths.
package dsp_pkg;

  localparam int AW_DEF = 32;
  localparam int PW_DEF = 17;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_HOLD  = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator with advance enable, registered top-PW slice plus a
// loadable phase offset, and a one-to-one sample strobe.
module phase_acc
  import dsp_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic [AW-1:0] inc,
  input  logic          off_load,
  input  logic [PW-1:0] off_in,
  output logic [PW-1:0] phase,
  output logic          strobe
);

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_sum;
  logic [PW-1:0] off;

  assign acc_sum = acc + inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      off    <= '0;
      phase  <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= adv;
      if (off_load) begin
        off <= off_in;
      end
      // Phase is only refreshed on advancing edges so it freezes otherwise.
      if (adv) begin
        acc   <= acc_sum;
        phase <= acc_sum[AW-1 -: PW] + off;
      end
    end
  end

endmodule

// File: rtl/phase_sweep_gen.sv
// Linear-chirp phase generator: sweeps frequency by a signed step for a set
// number of samples, then holds the final frequency.
module phase_sweep_gen
  import dsp_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_load,
  input  logic          i_abort,
  input  logic [AW-1:0] i_f_start,
  input  logic [AW-1:0] i_f_step,
  input  logic [CW-1:0] i_count,
  input  logic [PW-1:0] i_phase_off,
  output logic [PW-1:0] o_phase,
  output logic          o_aux,
  output logic          o_busy,
  output logic          o_done
);

  sweep_state_t  state, state_next;
  logic [AW-1:0] freq;
  logic [AW-1:0] step;
  logic [CW-1:0] cnt;
  logic          advance;
  logic          done_next;
  logic          param_load;

  // Commands: abort beats load, load beats normal advance; none need i_ce.
  always_comb begin
    state_next = state;
    advance    = 1'b0;
    done_next  = 1'b0;
    param_load = 1'b0;
    if (i_abort) begin
      state_next = ST_IDLE;
    end else if (i_load) begin
      param_load = 1'b1;
      if (i_count != '0) begin
        state_next = ST_SWEEP;
      end else begin
        state_next = ST_HOLD;
        done_next  = 1'b1;
      end
    end else if (i_ce && state != ST_IDLE) begin
      advance = 1'b1;
      if (state == ST_SWEEP && cnt == CW'(1)) begin
        state_next = ST_HOLD;
        done_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      freq   <= '0;
      step   <= '0;
      cnt    <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= done_next;
      if (param_load) begin
        freq <= i_f_start;
        step <= i_f_step;
        cnt  <= i_count;
      end else if (advance && state == ST_SWEEP) begin
        freq <= freq + step;
        cnt  <= cnt - CW'(1);
      end
    end
  end

  assign o_busy = (state == ST_SWEEP);

  phase_acc #(
    .AW(AW),
    .PW(PW)
  ) u_phase_acc (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .adv      (advance),
    .inc      (freq),
    .off_load (param_load),
    .off_in   (i_phase_off),
    .phase    (o_phase),
    .strobe   (o_aux)
  );

endmodule

// File: tb/tb_phase_sweep_gen.sv
// Bench for phase_sweep_gen: fixed vector table, hand-written corner
// sequences and randomized commands checked against a behavioural model.
module tb_phase_sweep_gen;

  localparam int AW = 32;
  localparam int PW = 17;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce;
  logic          load;
  logic          abort;
  logic [AW-1:0] f_start;
  logic [AW-1:0] f_step;
  logic [CW-1:0] count;
  logic [PW-1:0] phase_off;
  logic [PW-1:0] phase;
  logic          aux;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected output word: {phase, aux, busy, done}.
  logic [PW+2:0] exp_q[$];

  phase_sweep_gen #(.AW(AW), .PW(PW), .CW(CW)) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_ce        (ce),
    .i_load      (load),
    .i_abort     (abort),
    .i_f_start   (f_start),
    .i_f_step    (f_step),
    .i_count     (count),
    .i_phase_off (phase_off),
    .o_phase     (phase),
    .o_aux       (aux),
    .o_busy      (busy),
    .o_done      (done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Generator is "running" after any load; remaining sweep steps decide
  // whether the frequency still moves.
  logic [AW-1:0] m_acc, m_freq, m_step;
  logic [PW-1:0] m_off, m_phase;
  int            m_left;
  bit            m_running, m_aux, m_done;

  function automatic void model_reset();
    m_acc = '0; m_freq = '0; m_step = '0; m_off = '0; m_phase = '0;
    m_left = 0; m_running = 0; m_aux = 0; m_done = 0;
  endfunction

  function automatic void model_edge(input logic r, c, ld, ab,
                                     input logic [AW-1:0] fs, fst,
                                     input logic [CW-1:0] cn,
                                     input logic [PW-1:0] po);
    m_aux  = 0;
    m_done = 0;
    if (!r) begin
      model_reset();
    end else if (ab) begin
      m_running = 0;
    end else if (ld) begin
      m_running = 1;
      m_freq = fs; m_step = fst; m_left = int'(cn); m_off = po;
      m_done = (cn == 0);
    end else if (m_running && c) begin
      m_acc   = m_acc + m_freq;
      m_phase = PW'(m_acc / (2 ** (AW - PW))) + m_off;
      m_aux   = 1;
      if (m_left > 0) begin
        m_freq = m_freq + m_step;
        m_left = m_left - 1;
        m_done = (m_left == 0);
      end
    end
  endfunction

  function automatic logic [PW+2:0] model_out();
    return {m_phase, m_aux, (m_running && m_left > 0), m_done};
  endfunction

  // ---------------- driver / scoreboard ----------------
  task automatic check(input string name, input logic [PW+2:0] act, input logic [PW+2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got phase=%h aux=%b busy=%b done=%b, expected phase=%h aux=%b busy=%b done=%b",
               name, act[PW+2:3], act[2], act[1], act[0], exp[PW+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input logic r, c, ld, ab,
                      input logic [AW-1:0] fs, fst,
                      input logic [CW-1:0] cn,
                      input logic [PW-1:0] po);
    logic [PW+2:0] e;
    rst_n = r; ce = c; load = ld; abort = ab;
    f_start = fs; f_step = fst; count = cn; phase_off = po;
    model_edge(r, c, ld, ab, fs, fst, cn, po);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("model", {phase, aux, busy, done}, e);
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic hard_reset();
    step(0, 0, 0, 0, '0, '0, '0, '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          r, c, ld, ab;
    logic [AW-1:0] fs, fst;
    logic [CW-1:0] cn;
    logic [PW-1:0] po;
    logic [PW-1:0] ph;
    logic          ax, bz, dn;
  } vec_t;

  vec_t vt[15];

  initial begin
    rst_n = 0; ce = 0; load = 0; abort = 0;
    f_start = '0; f_step = '0; count = '0; phase_off = '0;
    model_reset();

    // Reset, idle with ce, then a 4-step chirp from 0 with step 0x8000.
    vt[0]  = '{0,0,0,0, 0,0,0,0,        0,0,0,0};
    vt[1]  = '{0,1,0,0, 0,0,0,0,        0,0,0,0};
    vt[2]  = '{0,1,0,0, 0,0,0,0,        0,0,0,0};
    vt[3]  = '{1,1,0,0, 0,0,0,0,        0,0,0,0};
    vt[4]  = '{1,0,1,0, 0,32'h8000,4,0, 0,0,1,0};
    vt[5]  = '{1,1,0,0, 0,0,0,0,        0,1,1,0};
    vt[6]  = '{1,1,0,0, 0,0,0,0,        1,1,1,0};
    vt[7]  = '{1,1,0,0, 0,0,0,0,        3,1,1,0};
    vt[8]  = '{1,1,0,0, 0,0,0,0,        6,1,0,1};
    vt[9]  = '{1,1,0,0, 0,0,0,0,       10,1,0,0};
    vt[10] = '{1,1,0,0, 0,0,0,0,       14,1,0,0};
    vt[11] = '{1,0,0,0, 0,0,0,0,       14,0,0,0};
    vt[12] = '{1,1,0,0, 0,0,0,0,       18,1,0,0};
    vt[13] = '{1,1,0,1, 0,0,0,0,       18,0,0,0};
    vt[14] = '{1,1,0,0, 0,0,0,0,       18,0,0,0};

    for (int i = 0; i < 15; i++) begin
      step(vt[i].r, vt[i].c, vt[i].ld, vt[i].ab, vt[i].fs, vt[i].fst, vt[i].cn, vt[i].po);
      check($sformatf("table[%0d]", i), {phase, aux, busy, done},
            {vt[i].ph, vt[i].ax, vt[i].bz, vt[i].dn});
    end

    // Fixed tone with ce pattern 1,0,0,1.
    hard_reset();
    step(1, 0, 1, 0, 32'h8000, 0, 0, 0);
    check("tone_load_done", {phase, aux, busy, done}, {17'd0, 1'b0, 1'b0, 1'b1});
    adv(3);
    check("tone_third", {phase, aux, busy, done}, {17'd3, 1'b1, 1'b0, 1'b0});
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("tone_ce_hold", {phase, aux, busy, done}, {17'd3, 1'b0, 1'b0, 1'b0});
    adv(1);
    check("tone_ce_resume", {phase, aux, busy, done}, {17'd4, 1'b1, 1'b0, 1'b0});

    // Load during HOLD keeps the accumulator and doubles the rate.
    step(1, 1, 1, 0, 32'h10000, 0, 0, 0);
    check("hold_reload", {phase, aux, busy, done}, {17'd4, 1'b0, 1'b0, 1'b1});
    adv(1);
    check("hold_reload_adv", {phase, aux, busy, done}, {17'd6, 1'b1, 1'b0, 1'b0});

    // Abort a chirp after two samples.
    hard_reset();
    step(1, 0, 1, 0, 0, 32'h8000, 4, 0);
    adv(2);
    step(1, 1, 0, 1, 0, 0, 0, 0);
    check("abort_freeze", {phase, aux, busy, done}, {17'd1, 1'b0, 1'b0, 1'b0});
    adv(2);
    check("abort_idle", {phase, aux, busy, done}, {17'd1, 1'b0, 1'b0, 1'b0});

    // Simultaneous abort and load stays idle.
    step(1, 1, 1, 1, 32'h8000, 0, 0, 0);
    check("abort_load", {phase, aux, busy, done}, {17'd1, 1'b0, 1'b0, 1'b0});
    adv(1);
    check("abort_load_idle", {phase, aux, busy, done}, {17'd1, 1'b0, 1'b0, 1'b0});

    // Full phase wrap with a coarse tone (4096 LSB per sample).
    hard_reset();
    step(1, 0, 1, 0, 32'h0800_0000, 0, 0, 0);
    adv(31);
    check("wrap_pre", {phase, aux, busy, done}, {17'h1F000, 1'b1, 1'b0, 1'b0});
    adv(1);
    check("wrap_zero", {phase, aux, busy, done}, {17'd0, 1'b1, 1'b0, 1'b0});

    // Offset wrap, then mid-run reset.
    hard_reset();
    step(1, 0, 1, 0, 32'h8000, 0, 0, 17'h1FFFF);
    adv(1);
    check("off_first", {phase, aux, busy, done}, {17'd0, 1'b1, 1'b0, 1'b0});
    adv(4);
    check("off_fifth", {phase, aux, busy, done}, {17'd4, 1'b1, 1'b0, 1'b0});
    hard_reset();
    check("mid_reset", {phase, aux, busy, done}, {17'd0, 1'b0, 1'b0, 1'b0});

    // Randomized commands against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 39) == 0,
           $urandom(), $urandom(),
           CW'($urandom_range(0, 8)),
           PW'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
